// File: rtl/alu_exec_unit.sv
// alu_exec_unit: ALU control + execute stage with registered single-cycle ops and iterative MUL/DIV.
// Optional feature macro: ALU_DIV_EN (adds signed DIV at ALUop=10, f7=0000001, f3=100).
// Ports: clk_i/rst_i (async active-low reset), flush_i; in_valid_i/in_ready_o with ALUop_i,
// func3_i, func7_i, a_i, b_i, tag_i; out_valid_o/out_ready_i with out_data_o, out_tag_o,
// out_err_o; busy_o high while an iterative op runs.
module alu_exec_unit #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [1:0]       ALUop_i,
  input  logic [2:0]       func3_i,
  input  logic [6:0]       func7_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [TAG_W-1:0] tag_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] out_data_o,
  output logic [TAG_W-1:0] out_tag_o,
  output logic             out_err_o,
  output logic             busy_o
);
  localparam int SW = $clog2(WIDTH);
  localparam int CW = SW + 2;
  typedef enum logic [1:0] {S_IDLE, S_MUL `ifdef ALU_DIV_EN , S_DIV `endif} state_t;
  typedef enum logic [3:0] {OP_ADD, OP_SUB, OP_AND, OP_XOR, OP_SLL, OP_SRA, OP_MUL, OP_DIV, OP_ILL} op_t;
  state_t           state_q;
  op_t              op_d;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] acc_q, x_q, y_q, res_d, sra_d;
  logic [TAG_W-1:0] tag_q, out_tag_q;
  logic [WIDTH-1:0] out_data_q;
  logic             out_valid_q, out_err_q, accept;
`ifdef ALU_DIV_EN
  logic             neg_q, dz_q, ge_d;
  logic [WIDTH-1:0] r_d;
  // Restoring step: shift next dividend bit into the partial remainder.
  assign r_d  = {acc_q[WIDTH-2:0], y_q[WIDTH-1]};
  assign ge_d = r_d >= x_q;
`endif
  always_comb begin
    op_d = OP_ILL;
    casez ({ALUop_i, func7_i, func3_i})
      12'b01_???????_???, 12'b00_???????_000, 12'b10_0000000_000: op_d = OP_ADD;
      12'b11_???????_???, 12'b10_0100000_000: op_d = OP_SUB;
      12'b00_0100000_101: op_d = OP_SRA;
      12'b10_0000000_111: op_d = OP_AND;
      12'b10_0000000_100: op_d = OP_XOR;
      12'b10_0000000_001: op_d = OP_SLL;
      12'b10_0000001_000: op_d = OP_MUL;
`ifdef ALU_DIV_EN
      12'b10_0000001_100: op_d = OP_DIV;
`endif
      default:            op_d = OP_ILL;
    endcase
  end
  // Kept as its own assignment so the shift stays signed (arithmetic).
  assign sra_d = $signed(a_i) >>> b_i[SW-1:0];
  always_comb begin
    res_d = op_d == OP_ADD ? a_i + b_i :
            op_d == OP_SUB ? a_i - b_i :
            op_d == OP_AND ? a_i & b_i :
            op_d == OP_XOR ? a_i ^ b_i :
            op_d == OP_SLL ? a_i << b_i[SW-1:0] :
            op_d == OP_SRA ? sra_d : '0;
  end
  assign in_ready_o  = (state_q == S_IDLE) & (!out_valid_q | out_ready_i) & !flush_i;
  assign accept      = in_valid_i & in_ready_o;
  assign busy_o      = state_q != S_IDLE;
  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign out_tag_o   = out_tag_q;
  assign out_err_o   = out_err_q;
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      acc_q       <= '0;
      x_q         <= '0;
      y_q         <= '0;
      tag_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_tag_q   <= '0;
      out_err_q   <= 1'b0;
`ifdef ALU_DIV_EN
      neg_q       <= 1'b0;
      dz_q        <= 1'b0;
`endif
    end else if (flush_i) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      if (out_ready_i) out_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: if (accept) begin
          tag_q <= tag_i;
          if (op_d == OP_MUL) begin
            state_q <= S_MUL;
            cnt_q   <= CW'(WIDTH);
            acc_q   <= '0;
            x_q     <= a_i;
            y_q     <= b_i;
          end
`ifdef ALU_DIV_EN
          else if (op_d == OP_DIV) begin
            // One extra count for the sign-fixup cycle after the WIDTH divide steps.
            state_q <= S_DIV;
            cnt_q   <= CW'(WIDTH + 1);
            acc_q   <= '0;
            x_q     <= b_i[WIDTH-1] ? -b_i : b_i;
            y_q     <= a_i[WIDTH-1] ? -a_i : a_i;
            neg_q   <= a_i[WIDTH-1] ^ b_i[WIDTH-1];
            dz_q    <= b_i == '0;
          end
`endif
          else begin
            out_valid_q <= 1'b1;
            out_data_q  <= res_d;
            out_err_q   <= op_d == OP_ILL;
            out_tag_q   <= tag_i;
          end
        end
        S_MUL: if (cnt_q == '0) begin
          state_q     <= S_IDLE;
          out_valid_q <= 1'b1;
          out_data_q  <= acc_q;
          out_err_q   <= 1'b0;
          out_tag_q   <= tag_q;
        end else begin
          acc_q <= acc_q + (y_q[0] ? x_q : '0);
          x_q   <= x_q << 1;
          y_q   <= y_q >> 1;
          cnt_q <= cnt_q - CW'(1);
        end
`ifdef ALU_DIV_EN
        S_DIV: if (cnt_q == '0) begin
          state_q     <= S_IDLE;
          out_valid_q <= 1'b1;
          out_data_q  <= acc_q;
          out_err_q   <= 1'b0;
          out_tag_q   <= tag_q;
        end else if (cnt_q == CW'(1)) begin
          acc_q <= dz_q ? '1 : neg_q ? -y_q : y_q;
          cnt_q <= cnt_q - CW'(1);
        end else begin
          acc_q <= ge_d ? r_d - x_q : r_d;
          y_q   <= {y_q[WIDTH-2:0], ge_d};
          cnt_q <= cnt_q - CW'(1);
        end
`endif
        default: state_q <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit: directed vectors checked against a behavioural model of alu_exec_unit.
module tb_alu_exec_unit;
  localparam int W = 32;
  logic          clk_i = 1'b0, rst_i = 1'b0, flush_i = 1'b0, in_valid_i = 1'b0, out_ready_i = 1'b1;
  logic          in_ready_o, out_valid_o, out_err_o, busy_o;
  logic [1:0]    ALUop_i = '0;
  logic [2:0]    func3_i = '0;
  logic [6:0]    func7_i = '0;
  logic [W-1:0]  a_i = '0, b_i = '0, out_data_o;
  logic [4:0]    tag_i = '0, out_tag_o;
  typedef struct {logic [W-1:0] d; logic e; logic [4:0] t; int due;} exp_t;
  exp_t q[$];
  int cyc = 0, total = 0, bad = 0;

  alu_exec_unit #(.WIDTH(W), .TAG_W(5)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .ALUop_i(ALUop_i), .func3_i(func3_i), .func7_i(func7_i), .a_i(a_i), .b_i(b_i), .tag_i(tag_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_data_o(out_data_o),
    .out_tag_o(out_tag_o), .out_err_o(out_err_o), .busy_o(busy_o));

  always #5 clk_i = ~clk_i;

  // Result and latency (edges after the accept edge) straight from the instruction semantics.
  function automatic exp_t model(input logic [1:0] op, input logic [2:0] f3, input logic [6:0] f7,
                                 input logic [W-1:0] a, input logic [W-1:0] b, input logic [4:0] t,
                                 input int now);
    exp_t r;
    logic [W-1:0] s;
    int lat;
    s = $signed(a) >>> b[4:0];
    r.t = t; r.e = 1'b0; r.d = '0; lat = 0;
    if (op == 2'b01) r.d = a + b;
    else if (op == 2'b11) r.d = a - b;
    else if (op == 2'b00 && f3 == 3'd0) r.d = a + b;
    else if (op == 2'b00 && f3 == 3'd5 && f7 == 7'h20) r.d = s;
    else if (op == 2'b10 && f7 == 7'h00 && f3 == 3'd0) r.d = a + b;
    else if (op == 2'b10 && f7 == 7'h00 && f3 == 3'd7) r.d = a & b;
    else if (op == 2'b10 && f7 == 7'h00 && f3 == 3'd4) r.d = a ^ b;
    else if (op == 2'b10 && f7 == 7'h00 && f3 == 3'd1) r.d = a << b[4:0];
    else if (op == 2'b10 && f7 == 7'h20 && f3 == 3'd0) r.d = a - b;
    else if (op == 2'b10 && f7 == 7'h01 && f3 == 3'd0) begin r.d = a * b; lat = W + 1; end
`ifdef ALU_DIV_EN
    else if (op == 2'b10 && f7 == 7'h01 && f3 == 3'd4) begin
      lat = W + 2;
      if (b == '0) r.d = '1;
      else if (a == 32'h8000_0000 && b == '1) r.d = a;
      else r.d = $signed(a) / $signed(b);
    end
`endif
    else r.e = 1'b1;
    r.due = now + lat;
    return r;
  endfunction

  function automatic logic mready();
    return !flush_i && (q.size() == 0 || (cyc >= q[0].due && out_ready_i));
  endfunction

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic fail(input string nm);
    total++; bad++;
    $display("FAIL %s: timed out (cycle %0d)", nm, cyc);
  endtask

  // Scoreboard update at each active edge from the bench's own view of ready/valid.
  initial forever begin
    logic rdy;
    @(posedge clk_i);
    if (!rst_i || flush_i) q.delete();
    else begin
      rdy = mready();
      if (q.size() != 0 && cyc >= q[0].due && out_ready_i) void'(q.pop_front());
      if (in_valid_i && rdy) q.push_back(model(ALUop_i, func3_i, func7_i, a_i, b_i, tag_i, cyc + 1));
    end
    cyc++;
  end

  // Every-cycle comparison of the DUT against the model.
  initial forever begin
    logic ev;
    @(negedge clk_i);
    if (rst_i) begin
      ev = q.size() != 0 && cyc >= q[0].due;
      chk("out_valid", out_valid_o, ev);
      chk("busy", busy_o, q.size() != 0 && cyc < q[0].due);
      chk("in_ready", in_ready_o, mready());
      if (ev) begin
        chk("out_data", out_data_o, q[0].d);
        chk("out_err", out_err_o, q[0].e);
        chk("out_tag", out_tag_o, q[0].t);
      end
    end
  end

  task automatic op(input logic [1:0] o, input logic [2:0] f3, input logic [6:0] f7,
                    input logic [W-1:0] a, input logic [W-1:0] b, input logic [4:0] t,
                    output logic [W-1:0] d, output logic e, output logic [4:0] tg, output int lat);
    int n;
    ALUop_i = o; func3_i = f3; func7_i = f7; a_i = a; b_i = b; tag_i = t;
    in_valid_i = 1'b1; out_ready_i = 1'b1;
    n = 0;
    while (!in_ready_o && n < 200) begin @(posedge clk_i); #1; n++; end
    if (n >= 200) fail("accept");
    @(posedge clk_i); #1;
    in_valid_i = 1'b0;
    lat = 0;
    while (!out_valid_o && lat < 100) begin @(posedge clk_i); #1; lat++; end
    if (lat >= 100) fail("result");
    d = out_data_o; e = out_err_o; tg = out_tag_o;
    @(posedge clk_i); #1;
  endtask

  initial begin
    logic [W-1:0] d;
    logic e;
    logic [4:0] tg;
    int lat;
    exp_t m;
    m = model(2'b01, 3'd0, 7'd0, 32'd5, 32'd7, 5'd3, 0);
    chk("model_add", m.d, 32'd12);
    m = model(2'b00, 3'd5, 7'h20, 32'h8000_0000, 32'd4, 5'd0, 0);
    chk("model_srai", m.d, 32'hF800_0000);
    m = model(2'b10, 3'd0, 7'h01, 32'd6, 32'd7, 5'd0, 0);
    chk("model_mul_lat", m.due, 33);
    repeat (3) @(posedge clk_i);
    #1;
    chk("rst_valid", out_valid_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_data", out_data_o, 0);
    chk("rst_err", out_err_o, 0);
    chk("rst_tag", out_tag_o, 0);
    #2 rst_i = 1'b1;
    @(posedge clk_i); #1;
    op(2'b01, 3'd0, 7'd0, 32'd5, 32'd7, 5'd3, d, e, tg, lat);
    chk("add_data", d, 32'd12); chk("add_tag", tg, 5'd3); chk("add_err", e, 0); chk("add_lat", lat, 0);
    op(2'b11, 3'd0, 7'd0, 32'd3, 32'd5, 5'd4, d, e, tg, lat);
    chk("sub_data", d, 32'hFFFF_FFFE);
    op(2'b00, 3'd5, 7'h20, 32'h8000_0000, 32'd4, 5'd5, d, e, tg, lat);
    chk("srai_data", d, 32'hF800_0000);
    op(2'b10, 3'd1, 7'h00, 32'd1, 32'h21, 5'd6, d, e, tg, lat);
    chk("sll_data", d, 32'd2);
    op(2'b00, 3'd0, 7'h7F, 32'd10, 32'hFFFF_FFFF, 5'd7, d, e, tg, lat);
    chk("addi_data", d, 32'd9);
    op(2'b10, 3'd7, 7'h00, 32'hF0F0_1234, 32'h0FF0_FF00, 5'd8, d, e, tg, lat);
    chk("and_data", d, 32'h00F0_1200);
    op(2'b10, 3'd0, 7'h20, 32'd1, 32'd2, 5'd9, d, e, tg, lat);
    chk("rsub_data", d, 32'hFFFF_FFFF);
    op(2'b10, 3'd0, 7'h01, 32'd6, 32'd7, 5'd10, d, e, tg, lat);
    chk("mul_data", d, 32'd42); chk("mul_lat", lat, 33); chk("mul_tag", tg, 5'd10);
    op(2'b10, 3'd0, 7'h01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd11, d, e, tg, lat);
    chk("mul_wrap", d, 32'd1);
    op(2'b10, 3'd2, 7'h01, 32'd9, 32'd9, 5'd12, d, e, tg, lat);
    chk("ill_err", e, 1); chk("ill_data", d, 0); chk("ill_lat", lat, 0);
    op(2'b00, 3'd1, 7'h00, 32'd9, 32'd9, 5'd13, d, e, tg, lat);
    chk("ill_i_err", e, 1);
`ifdef ALU_DIV_EN
    op(2'b10, 3'd4, 7'h01, 32'hFFFF_FFEC, 32'd3, 5'd14, d, e, tg, lat);
    chk("div_data", d, 32'hFFFF_FFFA); chk("div_lat", lat, 34); chk("div_err", e, 0);
    op(2'b10, 3'd4, 7'h01, 32'd123, 32'd0, 5'd15, d, e, tg, lat);
    chk("div0_data", d, 32'hFFFF_FFFF); chk("div0_err", e, 0);
    op(2'b10, 3'd4, 7'h01, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16, d, e, tg, lat);
    chk("divmin_data", d, 32'h8000_0000);
    op(2'b10, 3'd4, 7'h01, 32'd100, 32'hFFFF_FFF9, 5'd17, d, e, tg, lat);
    chk("divneg_data", d, 32'hFFFF_FFF2);
`else
    op(2'b10, 3'd4, 7'h01, 32'hFFFF_FFEC, 32'd3, 5'd14, d, e, tg, lat);
    chk("nodiv_err", e, 1); chk("nodiv_data", d, 0); chk("nodiv_lat", lat, 0);
`endif
    // Back-pressure then back-to-back accept on release.
    out_ready_i = 1'b0;
    ALUop_i = 2'b10; func3_i = 3'd0; func7_i = 7'h00; a_i = 32'd20; b_i = 32'd22; tag_i = 5'd18;
    in_valid_i = 1'b1;
    @(posedge clk_i); #1;
    in_valid_i = 1'b0;
    repeat (5) begin
      chk("bp_hold_data", out_data_o, 32'd42);
      chk("bp_in_ready", in_ready_o, 0);
      @(posedge clk_i); #1;
    end
    func3_i = 3'd4; a_i = 32'hAAAA_0000; b_i = 32'h0F0F_0F0F; tag_i = 5'd19;
    in_valid_i = 1'b1; out_ready_i = 1'b1;
    #1 chk("b2b_ready", in_ready_o, 1);
    @(posedge clk_i); #1;
    in_valid_i = 1'b0;
    chk("xor_data", out_data_o, 32'hA5A5_0F0F);
    chk("xor_tag", out_tag_o, 5'd19);
    @(posedge clk_i); #1;
    // Flush at MUL cycle 10.
    ALUop_i = 2'b10; func3_i = 3'd0; func7_i = 7'h01; a_i = 32'd3; b_i = 32'd3; tag_i = 5'd20;
    in_valid_i = 1'b1;
    @(posedge clk_i); #1;
    in_valid_i = 1'b0;
    repeat (9) @(posedge clk_i);
    #1 flush_i = 1'b1;
    @(posedge clk_i); #1;
    flush_i = 1'b0;
    chk("flush_busy", busy_o, 0);
    chk("flush_valid", out_valid_o, 0);
    repeat (40) @(posedge clk_i);
    #1 chk("flush_no_result", out_valid_o, 0);
    op(2'b01, 3'd0, 7'd0, 32'd100, 32'd1, 5'd21, d, e, tg, lat);
    chk("post_flush_add", d, 32'd101); chk("post_flush_lat", lat, 0);
    // Asynchronous reset in the middle of a MUL.
    ALUop_i = 2'b10; func3_i = 3'd0; func7_i = 7'h01; a_i = 32'd5; b_i = 32'd5; tag_i = 5'd22;
    in_valid_i = 1'b1;
    @(posedge clk_i); #1;
    in_valid_i = 1'b0;
    repeat (5) @(posedge clk_i);
    #2 rst_i = 1'b0;
    #1;
    chk("arst_busy", busy_o, 0);
    chk("arst_valid", out_valid_o, 0);
    chk("arst_data", out_data_o, 0);
    chk("arst_tag", out_tag_o, 0);
    repeat (2) @(posedge clk_i);
    #3 rst_i = 1'b1;
    repeat (40) @(posedge clk_i);
    #1 chk("arst_no_result", out_valid_o, 0);
    op(2'b10, 3'd0, 7'h01, 32'd12, 32'd12, 5'd23, d, e, tg, lat);
    chk("post_rst_mul", d, 32'd144);
    repeat (3) @(posedge clk_i);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
